// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: bus-mapped 8N1 UART transmitter with a byte FIFO; define MMIO_UART_TX_IRQ_EN to add IRQEN at offset 3 and an irq output
module mmio_uart_tx #(
    parameter int          FIFO_DEPTH  = 16,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [1:0]  data_mem_addr,
    input  logic [3:0]  data_mem_wmask,
    input  logic [31:0] data_mem_write,
    input  logic        data_mem_w_en,
    output logic [31:0] data_mem_read,
    output logic        tx
`ifdef MMIO_UART_TX_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state_q, state_d;
    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     div_q, div_d, baud_cnt_q, baud_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic [31:0]     rdata_q, rdata_d, reg3;
    logic            wr_acc, push, push_ok, full, empty, pop, busy, bit_end;
    logic [8:0]      count9;
    logic            unused_ok;

    always_comb begin
        wr_acc  = sel && data_mem_w_en;
        push    = wr_acc && data_mem_addr == 2'd0 && data_mem_wmask[0];
        full    = count_q == (AW+1)'(FIFO_DEPTH);
        empty   = count_q == '0;
        push_ok = push && !full;
        busy    = state_q != IDLE;
        bit_end = baud_cnt_q == '0;
        count9  = 9'(count_q);
    end

    // Full is judged before the FSM pops, so a push while full is always dropped.
    always_comb begin
        ovf_d    = (ovf_q && !(wr_acc && data_mem_addr == 2'd1 && data_mem_wmask[0] && data_mem_write[3]))
                   || (push && full);
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};
        div_d[15:8] = (wr_acc && data_mem_addr == 2'd2 && data_mem_wmask[1]) ? data_mem_write[15:8] : div_q[15:8];
        div_d[7:0]  = (wr_acc && data_mem_addr == 2'd2 && data_mem_wmask[0]) ? data_mem_write[7:0] : div_q[7:0];
        rdata_d  = !(sel && !data_mem_w_en)   ? 32'd0 :
                   data_mem_addr == 2'd0      ? 32'd0 :
                   data_mem_addr == 2'd1      ? {16'd0, count9[7:0], 4'd0, ovf_q, busy, empty, full} :
                   data_mem_addr == 2'd2      ? {16'd0, div_q} : reg3;
    end

    always_comb begin
        state_d    = state_q;
        baud_cnt_d = busy ? baud_cnt_q - 16'd1 : baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        pop        = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop        = 1'b1;
                    shift_d    = fifo_mem[rd_ptr_q];
                    state_d    = START;
                    baud_cnt_d = div_q;
                    tx_d       = 1'b0;
                end
            end
            START: begin
                if (bit_end) begin
                    state_d    = DATA;
                    baud_cnt_d = div_q;
                    bit_idx_d  = 3'd0;
                    tx_d       = shift_q[0];
                    shift_d    = shift_q >> 1;
                end
            end
            DATA: begin
                if (bit_end) begin
                    baud_cnt_d = div_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        shift_d    = fifo_mem[rd_ptr_q];
                        state_d    = START;
                        baud_cnt_d = div_q;
                        tx_d       = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        baud_cnt_d = 16'd0;
                        tx_d       = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            div_q      <= DEFAULT_DIV;
            baud_cnt_q <= 16'd0;
            bit_idx_q  <= 3'd0;
            shift_q    <= 8'd0;
            tx_q       <= 1'b1;
            rdata_q    <= 32'd0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            div_q      <= div_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            rdata_q    <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr_q] <= data_mem_write[7:0];
    end

`ifdef MMIO_UART_TX_IRQ_EN
    logic [1:0] irqen_q, irqen_d;
    logic       irq_q, irq_d;

    always_comb begin
        irqen_d = (wr_acc && data_mem_addr == 2'd3 && data_mem_wmask[0]) ? data_mem_write[1:0] : irqen_q;
        irq_d   = (irqen_q[0] && empty && !busy) || (irqen_q[1] && ovf_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            irqen_q <= 2'd0;
            irq_q   <= 1'b0;
        end else begin
            irqen_q <= irqen_d;
            irq_q   <= irq_d;
        end
    end

    assign reg3 = {30'd0, irqen_q};
    assign irq  = irq_q;
`else
    assign reg3 = 32'd0;
`endif

    assign data_mem_read = rdata_q;
    assign tx            = tx_q;
    assign unused_ok     = &{1'b0, data_mem_write[31:16], count9[8]};
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: scoreboard bench; bus reads and serial frames are checked by monitors against queued expectations
module tb_mmio_uart_tx;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel = 1'b0;
    logic [1:0]  addr = 2'd0;
    logic [3:0]  wmask = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        w_en = 1'b0;
    logic [31:0] rdata;
    logic        tx;
`ifdef MMIO_UART_TX_IRQ_EN
    logic        irq;
`endif

    mmio_uart_tx dut (
        .clk(clk),
        .reset(reset),
        .sel(sel),
        .data_mem_addr(addr),
        .data_mem_wmask(wmask),
        .data_mem_write(wdata),
        .data_mem_w_en(w_en),
        .data_mem_read(rdata),
        .tx(tx)
`ifdef MMIO_UART_TX_IRQ_EN
        ,
        .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          cur_div = 867;
    int          cyc = 0;
    logic        mon_en = 1'b1;
    logic        mon_busy = 1'b0;
    logic        rd_req_q = 1'b0;
    logic        wr_req_q = 1'b0;
    logic [31:0] rd_exp[$];
    logic [7:0]  tx_exp[$];
    int          starts[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    task automatic wr(input logic [1:0] a, input logic [3:0] m, input logic [31:0] d);
        sel = 1'b1; w_en = 1'b1; addr = a; wmask = m; wdata = d;
        @(posedge clk); #1;
        sel = 1'b0; w_en = 1'b0; wmask = 4'd0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        rd_exp.push_back(exp);
        sel = 1'b1; w_en = 1'b0; addr = a;
        @(posedge clk); #1;
        sel = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((tx_exp.size() != 0 || mon_busy) && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) fail("drain_timeout");
        idle(2);
    endtask

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rd_req_q <= sel && !w_en && reset;
        wr_req_q <= sel && w_en && reset;
    end

    always @(negedge clk) begin
        if (rd_req_q) begin
            if (rd_exp.size() == 0) fail("unexpected_read");
            else chk("read", rdata, rd_exp.pop_front());
        end else if (wr_req_q) chk("read_zero_on_write", rdata, 32'd0);
    end

    // Serial monitor: checks every clock of each frame against the expected bit.
    always begin
        @(negedge clk);
        if (mon_en && reset && tx === 1'b0) begin
            mon_busy = 1'b1;
            starts.push_back(cyc);
            if (tx_exp.size() == 0) fail("unexpected_frame");
            else begin
                logic [7:0] e;
                logic [9:0] frame;
                logic [7:0] got;
                int bad;
                e = tx_exp.pop_front();
                frame = {1'b1, e, 1'b0};
                got = 8'd0;
                bad = 0;
                for (int b = 0; b < 10; b++) begin
                    for (int c = 0; c <= cur_div; c++) begin
                        if (b != 0 || c != 0) @(negedge clk);
                        if (tx !== frame[b]) bad++;
                        if (c == 0 && b >= 1 && b <= 8) got[b-1] = tx;
                    end
                end
                chk("frame_byte", {24'd0, got}, {24'd0, e});
                chk("frame_shape_bad_cycles", bad, 0);
            end
            mon_busy = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        reset = 1'b0;
        @(posedge clk); @(posedge clk); #1;
        chk("reset_tx", {31'd0, tx}, 32'd1);
        chk("reset_rdata", rdata, 32'd0);
        reset = 1'b1;
        rd(2'd1, 32'h0000_0002);
        rd(2'd2, 32'h0000_0363);
        idle(1);
        chk("idle_tx", {31'd0, tx}, 32'd1);

        wr(2'd0, 4'b0010, 32'h77);
        rd(2'd1, 32'h0000_0002);
        wr(2'd2, 4'b0001, 32'h1234);
        rd(2'd2, 32'h0000_0334);
        rd(2'd0, 32'd0);
        rd(2'd3, 32'd0);

        wr(2'd2, 4'b0011, 32'd3);
        cur_div = 3;
        tx_exp.push_back(8'hA5);
        wr(2'd0, 4'b0001, 32'hA5);
        rd(2'd1, 32'h0000_0100);
        rd(2'd1, 32'h0000_0006);
        idle(20);
        rd(2'd1, 32'h0000_0006);
        wait_drain(200);
        rd(2'd1, 32'h0000_0002);

        wr(2'd2, 4'b0011, 32'd0);
        cur_div = 0;
        tx_exp.push_back(8'h55);
        tx_exp.push_back(8'hAA);
        wr(2'd0, 4'b0001, 32'h55);
        wr(2'd0, 4'b0001, 32'hAA);
        rd(2'd1, 32'h0000_0104);
        wait_drain(100);
        n = starts.size();
        if (n >= 2) chk("back_to_back_gap", starts[n-1] - starts[n-2], 32'd10);
        else fail("back_to_back_frames_missing");
        rd(2'd1, 32'h0000_0002);

        wr(2'd2, 4'b0011, 32'd100);
        cur_div = 100;
        tx_exp.push_back(8'h3C);
        wr(2'd0, 4'b0001, 32'h3C);
        idle(5);
        for (int i = 0; i < 17; i++) begin
            if (i < 16) tx_exp.push_back(8'(8'h10 + i));
            wr(2'd0, 4'b0001, 32'(8'h10 + i));
        end
        rd(2'd1, 32'h0000_100D);
        wr(2'd1, 4'b0001, 32'h8);
        rd(2'd1, 32'h0000_1005);
        wait_drain(20000);
        rd(2'd1, 32'h0000_0002);

        wr(2'd2, 4'b0011, 32'd3);
        cur_div = 3;
        mon_en = 1'b0;
        wr(2'd0, 4'b0001, 32'hF0);
        wr(2'd0, 4'b0001, 32'h0F);
        idle(10);
        chk("mid_frame_busy_setup", {31'd0, tx}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("abort_tx_high", {31'd0, tx}, 32'd1);
        reset = 1'b1;
        mon_en = 1'b1;
        rd(2'd1, 32'h0000_0002);
        rd(2'd2, 32'h0000_0363);
        idle(30);
`ifdef MMIO_UART_TX_IRQ_EN
        chk("irq_after_reset", {31'd0, irq}, 32'd0);
        wr(2'd3, 4'b0001, 32'd1);
        rd(2'd3, 32'd1);
        chk("irq_empty", {31'd0, irq}, 32'd1);
`endif
        idle(3);
        chk("read_queue_drained", rd_exp.size(), 32'd0);
        chk("tx_queue_drained", tx_exp.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
